alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode/issue stage that drives the ALU operand and control inputs. It accepts one RV32I instruction per cycle with its register-file operands and PC over a valid/ready handshake. It decodes the instruction into `aluctrl`, `aluop1`, `aluop2`, branch and writeback controls. It presents the result one cycle later to the execute stage over a second valid/ready handshake, with flush support.

## Interface
- `D_WIDTH`, 32, datapath width; only 32 is supported.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  stage can accept; transfer occurs when `in_valid && in_ready`.
- `instr`  in  32  RV32I instruction word.
- `rs1_data`, `rs2_data`  in  D_WIDTH  register operands.
- `pc`  in  D_WIDTH  instruction address.
- `flush`  in  1  discard all held entries.
- `out_valid`  out  1  decoded entry available.
- `out_ready`  in  1  execute consumes; transfer occurs when `out_valid && out_ready`.
- `aluop1`, `aluop2`  out  D_WIDTH  ALU operands.
- `aluctrl`  out  4  ALU operation code.
- `rd_addr`  out  5  destination register.
- `reg_write`  out  1  result is written back.
- `br_en`  out  1  conditional branch; the ALU `eq` decides it.
- `br_inv`  out  1  branch taken when `eq` == 0.
- `illegal`  out  1  unsupported opcode or funct.

## Operation
- **aluctrl codes:**
  - add 0000, sub 0001, and 0010, or 0011, xor 0100
  - slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001
- **R-type (0110011):** op1 = rs1, op2 = rs2. funct3/funct7 select the code; funct7 = 0100000 is legal only with funct3 000 (sub) or 101 (sra).
- **I-type ALU (0010011):**
  - op2 = sign-extended imm[11:0].
  - Shifts use op2 = {27'b0, instr[24:20]} (the ALU shifts by the full operand).
  - For shifts, instr[30] selects srl or sra; any other nonzero funct7 bit is illegal.
- **LUI:** op1 = 0, op2 = {instr[31:12], 12'b0}, add.
- **AUIPC:** op1 = pc, op2 is the same immediate, add.
- **Load/store:** add with rs1 and the sign-extended I-imm or S-imm. `reg_write` = 1 for loads only.
- **Branch (1100011):** `br_en` = 1, `reg_write` = 0.
  - BEQ: sub, inv 0. BNE: sub, inv 1.
  - BLT: slt, inv 0. BGE: slt, inv 1.
  - BLTU: sltu, inv 0. BGEU: sltu, inv 1.
  - funct3 010 and 011 are illegal.
- **Illegal entry:** `illegal` = 1, `aluctrl` = 0000, `reg_write` = 0, `br_en` = 0; the entry still flows through.
- **`reg_write`:** 1 for R, I-ALU, LUI, AUIPC and load; forced to 0 when `rd_addr` = 0.
- **Buffer FSM:** states EMPTY, ONE, TWO (main register plus skid register).
  - Accept and no consume: EMPTY→ONE, ONE→TWO.
  - Consume and no accept: TWO→ONE, ONE→EMPTY.
  - Accept and consume together: state is unchanged.
- **Ordering:** strict FIFO. Outputs always reflect the main register and are held stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs with `out_valid` = 1 after edge N.
- Throughput is one instruction per cycle when `out_ready` = 1.
- **Reset:**
  - `out_valid`, `aluop1`, `aluop2`, `aluctrl`, `rd_addr`, `reg_write`, `br_en`, `br_inv`, `illegal` are all 0.
  - `in_ready` = 1; state is EMPTY.
- **Reset mid-operation:** all held entries are lost immediately (asynchronous).
- **Flush:** state becomes EMPTY at the next edge and `out_valid` = 0. An input handshaked in the same cycle is also dropped (flush wins). `in_ready` is 1 in the following cycle.
- **Consume and accept in ONE:** the new entry replaces the main register with no bubble.

## Configuration
- **`ALU_DEC_SKID_EN` defined:**
  - Two-entry buffer as described.
  - `in_ready` is registered, equal to state != TWO.
- **`ALU_DEC_SKID_EN` undefined:**
  - Single entry; the TWO state does not exist.
  - `in_ready` = `!out_valid || out_ready` (combinational path from `out_ready`).
  - Latency, reset and flush rules are unchanged.

## Structure
- **Package `alu_pkg`:**
  - aluctrl code constants (as a 4-bit enum).
  - Opcode constants.
  - Packed struct for a decoded entry (op1, op2, ctrl, rd, reg_write, br_en, br_inv, illegal).
- **Sub-module `alu_ctrl_dec`:** purely combinational, instr/rs1/rs2/pc → decoded struct. The stage instantiates it once, ahead of the buffer.

## Test plan
- **ADD:** `instr` = 0x002081B3, rs1 = 5, rs2 = 7 → next cycle `aluctrl` = 0000, op1 = 5, op2 = 7, `rd_addr` = 3, `reg_write` = 1, `illegal` = 0.
- **SRAI:** `instr` = 0x4030D293, rs1 = 0xF0000000 → `aluctrl` = 1001, op2 = 3, `rd_addr` = 5.
- **BNE and LUI:**
  - BNE `instr` = 0x00209063 → `aluctrl` = 0001, `br_en` = 1, `br_inv` = 1, `reg_write` = 0.
  - LUI `instr` = 0x123450B7 → op1 = 0, op2 = 0x12345000, `aluctrl` = 0000.
- **Backpressure:** hold `out_ready` = 0 while offering 3 instructions.
  - With `ALU_DEC_SKID_EN`: 2 accepted, then `in_ready` = 0; outputs stay stable.
  - Release `out_ready`: entries emerge in order, one per cycle.
- **Flush and reset:**
  - In TWO, assert `flush` together with `in_valid` → next cycle `out_valid` = 0 and `in_ready` = 1; the input is dropped.
  - Assert `rst` mid-stream → all outputs 0 immediately.
- **Illegal:** `instr` = 0xFFFFFFFF → `illegal` = 1, `aluctrl` = 0000, `reg_write` = 0, `br_en` = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU decode/issue stage.
// ALU operation codes, RV32I opcodes and the decoded-entry record.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluAnd  = 4'b0010,
        AluOr   = 4'b0011,
        AluXor  = 4'b0100,
        AluSlt  = 4'b0101,
        AluSltu = 4'b0110,
        AluSll  = 4'b0111,
        AluSrl  = 4'b1000,
        AluSra  = 4'b1001
    } alu_ctrl_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_ctrl_e   ctrl;
        logic [4:0]  rd;
        logic        reg_write;
        logic        br_en;
        logic        br_inv;
        logic        illegal;
    } dec_entry_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder: instruction plus operands and PC into one
// decoded ALU entry. Illegal encodings are flagged and neutralised here.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    output dec_entry_t  dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        ill;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        dec      = '0;
        ill      = 1'b0;
        dec.rd   = instr[11:7];
        dec.op1  = rs1_data;
        dec.op2  = rs2_data;
        dec.ctrl = AluAdd;
        case (opcode)
            OpcOp: begin
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.ctrl = AluAdd;
                        3'b001:  dec.ctrl = AluSll;
                        3'b010:  dec.ctrl = AluSlt;
                        3'b011:  dec.ctrl = AluSltu;
                        3'b100:  dec.ctrl = AluXor;
                        3'b101:  dec.ctrl = AluSrl;
                        3'b110:  dec.ctrl = AluOr;
                        default: dec.ctrl = AluAnd;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.ctrl = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.ctrl = AluSra;
                end else begin
                    ill = 1'b1;
                end
            end
            OpcOpImm: begin
                dec.reg_write = 1'b1;
                dec.op2       = imm_i;
                case (funct3)
                    3'b000: dec.ctrl = AluAdd;
                    3'b010: dec.ctrl = AluSlt;
                    3'b011: dec.ctrl = AluSltu;
                    3'b100: dec.ctrl = AluXor;
                    3'b110: dec.ctrl = AluOr;
                    3'b111: dec.ctrl = AluAnd;
                    3'b001: begin
                        dec.op2  = shamt;
                        dec.ctrl = AluSll;
                        ill      = (funct7 != 7'b0000000);
                    end
                    default: begin
                        // Only instr[30] may be set: it picks arithmetic shift.
                        dec.op2  = shamt;
                        dec.ctrl = instr[30] ? AluSra : AluSrl;
                        ill      = ({funct7[6], funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            OpcLui: begin
                dec.reg_write = 1'b1;
                dec.op1       = '0;
                dec.op2       = imm_u;
            end
            OpcAuipc: begin
                dec.reg_write = 1'b1;
                dec.op1       = pc;
                dec.op2       = imm_u;
            end
            OpcLoad: begin
                dec.reg_write = 1'b1;
                dec.op2       = imm_i;
            end
            OpcStore: begin
                dec.op2 = imm_s;
            end
            OpcBranch: begin
                dec.br_en = 1'b1;
                case (funct3)
                    3'b000: dec.ctrl = AluSub;
                    3'b001: begin dec.ctrl = AluSub;  dec.br_inv = 1'b1; end
                    3'b100: dec.ctrl = AluSlt;
                    3'b101: begin dec.ctrl = AluSlt;  dec.br_inv = 1'b1; end
                    3'b110: dec.ctrl = AluSltu;
                    3'b111: begin dec.ctrl = AluSltu; dec.br_inv = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            dec.ctrl      = AluAdd;
            dec.reg_write = 1'b0;
            dec.br_en     = 1'b0;
            dec.br_inv    = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
        dec.illegal = ill;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode/issue stage feeding the ALU over valid/ready handshakes.
// Define ALU_DEC_SKID_EN for a two-entry buffer with registered in_ready.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [D_WIDTH-1:0] rs1_data,
    input  logic [D_WIDTH-1:0] rs2_data,
    input  logic [D_WIDTH-1:0] pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] aluop1,
    output logic [D_WIDTH-1:0] aluop2,
    output logic [3:0]         aluctrl,
    output logic [4:0]         rd_addr,
    output logic               reg_write,
    output logic               br_en,
    output logic               br_inv,
    output logic               illegal
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;

    dec_entry_t dec;
    dec_entry_t main_q, main_d;
    logic [1:0] state_q, state_d;
    logic       accept;
    logic       consume;

    alu_ctrl_dec u_alu_ctrl_dec (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pc       (pc),
        .dec      (dec)
    );

    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

`ifdef ALU_DEC_SKID_EN
    localparam logic [1:0] StTwo = 2'd2;

    dec_entry_t skid_q, skid_d;

    // Depends only on state, so no combinational path from out_ready.
    assign in_ready = (state_q != StTwo);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = StTwo;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            main_d  = dec;
            state_d = StOne;
        end else if (consume) begin
            state_d = StEmpty;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    assign aluop1    = main_q.op1;
    assign aluop2    = main_q.op2;
    assign aluctrl   = main_q.ctrl;
    assign rd_addr   = main_q.rd;
    assign reg_write = main_q.reg_write;
    assign br_en     = main_q.br_en;
    assign br_inv    = main_q.br_inv;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: decode vector table plus
// backpressure, flush and reset sequences (adapts to ALU_DEC_SKID_EN).
module tb_alu_decode_stage;

`ifdef ALU_DEC_SKID_EN
    localparam int BufDepth = 2;
`else
    localparam int BufDepth = 1;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluop1;
    logic [31:0] aluop2;
    logic [3:0]  aluctrl;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        br_en;
    logic        br_inv;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_decode_stage #(.D_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .pc        (pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluop1    (aluop1),
        .aluop2    (aluop2),
        .aluctrl   (aluctrl),
        .rd_addr   (rd_addr),
        .reg_write (reg_write),
        .br_en     (br_en),
        .br_inv    (br_inv),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic        chk_ops;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        inv;
        logic        ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string n, input logic [31:0] i, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] p, input logic co,
                                 input logic [31:0] o1, input logic [31:0] o2,
                                 input logic [3:0] c, input logic [4:0] rd, input logic rw,
                                 input logic br, input logic inv, input logic ill);
        vec_t v;
        v.name = n; v.instr = i; v.rs1 = r1; v.rs2 = r2; v.pc = p; v.chk_ops = co;
        v.op1 = o1; v.op2 = o2; v.ctrl = c; v.rd = rd; v.rw = rw; v.br = br;
        v.inv = inv; v.ill = ill;
        return v;
    endfunction

    // ADD rd, x1, x2
    function automatic logic [31:0] mk_add(input int rd);
        logic [31:0] base;
        base = 32'h0020_8033;
        return base | (32'(rd) << 7);
    endfunction

    initial begin
        vec_t vecs[$];
        int   idx;
        logic hs;
        int   got[$];
        int   first;
        int   last;

        rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
        pc = '0; flush = 1'b0; out_ready = 1'b1;

        //               name     instr         rs1           rs2    pc     ops op1           op2           ctrl    rd rw br inv ill
        vecs.push_back(mkv("add",   32'h002081B3, 32'd5,        32'd7, 32'h0, 1, 32'd5,        32'd7,        4'b0000, 3, 1, 0, 0, 0));
        vecs.push_back(mkv("sub",   32'h40208133, 32'd10,       32'd3, 32'h0, 1, 32'd10,       32'd3,        4'b0001, 2, 1, 0, 0, 0));
        vecs.push_back(mkv("sltu",  32'h0020B1B3, 32'd1,        32'd2, 32'h0, 1, 32'd1,        32'd2,        4'b0110, 3, 1, 0, 0, 0));
        vecs.push_back(mkv("srai",  32'h4030D293, 32'hF0000000, 32'd0, 32'h0, 1, 32'hF0000000, 32'd3,        4'b1001, 5, 1, 0, 0, 0));
        vecs.push_back(mkv("addi",  32'hFFF00093, 32'h11,       32'h22, 32'h0, 1, 32'h11,      32'hFFFFFFFF, 4'b0000, 1, 1, 0, 0, 0));
        vecs.push_back(mkv("lui",   32'h123450B7, 32'h55,       32'h66, 32'h0, 1, 32'h0,       32'h12345000, 4'b0000, 1, 1, 0, 0, 0));
        vecs.push_back(mkv("auipc", 32'h00001117, 32'h55,       32'h66, 32'h100, 1, 32'h100,   32'h00001000, 4'b0000, 2, 1, 0, 0, 0));
        vecs.push_back(mkv("lw",    32'h0080A203, 32'h2000,     32'd9, 32'h0, 1, 32'h2000,     32'd8,        4'b0000, 4, 1, 0, 0, 0));
        vecs.push_back(mkv("sw",    32'hFE20AE23, 32'h2000,     32'd9, 32'h0, 1, 32'h2000,     32'hFFFFFFFC, 4'b0000, 28, 0, 0, 0, 0));
        vecs.push_back(mkv("bne",   32'h00209063, 32'd1,        32'd2, 32'h0, 1, 32'd1,        32'd2,        4'b0001, 0, 0, 1, 1, 0));
        vecs.push_back(mkv("bgeu",  32'h0020F063, 32'd1,        32'd2, 32'h0, 1, 32'd1,        32'd2,        4'b0110, 0, 0, 1, 1, 0));
        vecs.push_back(mkv("add_x0", 32'h00208033, 32'd5,       32'd7, 32'h0, 1, 32'd5,        32'd7,        4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("ill_ff", 32'hFFFFFFFF, 32'd1,       32'd2, 32'h0, 0, 32'h0,        32'h0,        4'b0000, 31, 0, 0, 0, 1));
        vecs.push_back(mkv("ill_r",  32'h40209133, 32'd1,       32'd2, 32'h0, 0, 32'h0,        32'h0,        4'b0000, 2, 0, 0, 0, 1));
        vecs.push_back(mkv("ill_sh", 32'h40309293, 32'd1,       32'd2, 32'h0, 0, 32'h0,        32'h0,        4'b0000, 5, 0, 0, 0, 1));
        vecs.push_back(mkv("ill_br", 32'h0020A063, 32'd1,       32'd2, 32'h0, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 0, 1));

        // Reset values
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.aluop1", aluop1, 0);
        chk("rst.aluop2", aluop2, 0);
        chk("rst.ctrl", aluctrl, 0);
        chk("rst.rd", rd_addr, 0);
        chk("rst.flags", {reg_write, br_en, br_inv, illegal}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Decode table
        foreach (vecs[k]) begin
            @(negedge clk);
            in_valid = 1'b1; instr = vecs[k].instr; rs1_data = vecs[k].rs1;
            rs2_data = vecs[k].rs2; pc = vecs[k].pc;
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[k].name, ".valid"}, out_valid, 1);
            if (vecs[k].chk_ops) begin
                chk({vecs[k].name, ".op1"}, aluop1, vecs[k].op1);
                chk({vecs[k].name, ".op2"}, aluop2, vecs[k].op2);
            end
            chk({vecs[k].name, ".ctrl"}, aluctrl, vecs[k].ctrl);
            chk({vecs[k].name, ".rd"}, rd_addr, vecs[k].rd);
            chk({vecs[k].name, ".reg_write"}, reg_write, vecs[k].rw);
            chk({vecs[k].name, ".br_en"}, br_en, vecs[k].br);
            chk({vecs[k].name, ".br_inv"}, br_inv, vecs[k].inv);
            chk({vecs[k].name, ".illegal"}, illegal, vecs[k].ill);
        end

        // Back-to-back throughput with no bubble
        @(negedge clk);
        in_valid = 1'b1; instr = mk_add(6);
        @(negedge clk);
        chk("tput.a.valid", out_valid, 1);
        chk("tput.a.rd", rd_addr, 6);
        instr = mk_add(7);
        @(negedge clk);
        chk("tput.b.valid", out_valid, 1);
        chk("tput.b.rd", rd_addr, 7);
        in_valid = 1'b0;
        @(negedge clk);
        chk("tput.drain", out_valid, 0);

        // Backpressure: offer three with out_ready low
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (idx > 0) chk("bp.hold_rd", rd_addr, 3);
            if (idx < 3) begin
                in_valid = 1'b1;
                instr    = mk_add(idx + 3);
            end else begin
                in_valid = 1'b0;
            end
            #1 hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.accepted", idx, BufDepth);
        chk("bp.in_ready", in_ready, 0);
        chk("bp.out_valid", out_valid, 1);

        out_ready = 1'b1;
        first = -1;
        last  = -1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) begin
                got.push_back(int'(rd_addr));
                if (first < 0) first = c;
                last = c;
            end
            @(negedge clk);
        end
        chk("bp.drain_count", got.size(), BufDepth);
        chk("bp.drain_span", last - first, got.size() - 1);
        for (int i = 0; i < got.size() && i < BufDepth; i++) begin
            chk($sformatf("bp.order%0d", i), got[i], 3 + i);
        end

        // Flush while full, with a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1; instr = mk_add(10);
        @(negedge clk);
        instr = mk_add(11);
        @(negedge clk);
        flush = 1'b1; instr = mk_add(12);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", out_valid, 0);
        chk("flush.in_ready", in_ready, 1);

        // Flush wins over a real handshake in the same cycle
        out_ready = 1'b1;
        flush = 1'b1; in_valid = 1'b1; instr = mk_add(14);
        #1 chk("flushhs.in_ready", in_ready, 1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flushhs.dropped", out_valid, 0);
        @(negedge clk);
        chk("flushhs.still_empty", out_valid, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h123450B7;
        @(negedge clk);
        in_valid = 1'b0;
        chk("arst.pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.in_ready", in_ready, 1);
        chk("arst.aluop2", aluop2, 0);
        chk("arst.rd", rd_addr, 0);
        chk("arst.flags", {aluctrl, reg_write, br_en, br_inv, illegal}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
